seg7_bcd_display: RTL and testbench

- Parametrised successor to the team's fixed 4-digit Basys 3 seven-segment driver.
- Accepts a binary value over a valid/ready handshake and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, or to hex in one cycle. No `/` or `%` operators.
- Time-multiplexes NUM_DIGITS digits onto the common anode/cathode pins, with optional leading-zero blanking and overflow indication.
- Sits between datapath results (ROM/DSP outputs) and the board pins.

---
 rtl/seg7_bcd_display.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_bcd_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display
//   Shows an unsigned binary value on NUM_DIGITS multiplexed seven-segment
//   digits. Decimal values go through a sequential shift-add-3 (double-dabble)
//   engine, one bit per clock. Hex values are loaded in a single cycle.
//
// Ports
//   clock_100Mhz    sole clock, rising edge
//   reset           synchronous, active-high
//   load_valid      a new value is offered
//   load_ready      the block can accept a value (high only in IDLE)
//   load_value      unsigned binary value, BIN_WIDTH bits
//   hex_mode        sampled on accept: 1 = hexadecimal, 0 = decimal
//   blank_lz        sampled on accept: 1 = blank leading zeros
//   busy            decimal conversion in progress (state == CONV)
//   overflow        the displayed value does not fit in NUM_DIGITS digits
//   Anode_Activate  active-low digit enables, MSB = leftmost digit
//   LED_out         active-low cathodes a..g, MSB = a
//
// Handshake: a value is taken on any rising edge where load_valid and
// load_ready are both 1. load_ready depends only on the state register,
// never on load_valid. Offers made while busy are dropped, not queued.
module seg7_bcd_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int BIN_WIDTH    = 16,
  parameter int REFRESH_BITS = 18
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [BIN_WIDTH-1:0]  load_value,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int EW = BIN_WIDTH + DW;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t                  state;
  logic [BIN_WIDTH-1:0]    shift_reg;
  logic [DW-1:0]           bcd_acc;
  logic                    ovf_sticky;
  logic [CW-1:0]           bit_cnt;
  logic                    conv_blank;
  logic [DW-1:0]           disp_digits;
  logic                    disp_hex;
  logic                    disp_blank;
  logic [REFRESH_BITS-1:0] prescaler;
  logic [IW-1:0]           digit_idx;

  assign load_ready = (state == IDLE);
  assign busy       = (state == CONV);

  // One double-dabble step: correct every digit >= 5, then shift the
  // combined {bcd, binary} register left. A bit leaving the top digit means
  // the value needs more than NUM_DIGITS decimal digits.
  logic [DW-1:0]        bcd_adj;
  logic [DW-1:0]        bcd_next;
  logic                 carry_out;
  logic [BIN_WIDTH-1:0] shift_next;

  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
    {carry_out, bcd_next} = {bcd_adj, shift_reg[BIN_WIDTH-1]};
    shift_next = shift_reg << 1;
  end

  // Zero-extended so that the nibble slice and the overflow shift are legal
  // whether the value is wider or narrower than the digit field.
  logic [EW-1:0] hex_ext;
  logic          hex_ovf;
  assign hex_ext = EW'(load_value);
  assign hex_ovf = |(hex_ext >> DW);

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bcd_acc     <= '0;
      ovf_sticky  <= 1'b0;
      bit_cnt     <= '0;
      conv_blank  <= 1'b0;
      disp_digits <= '0;
      disp_hex    <= 1'b0;
      disp_blank  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            if (hex_mode) begin
              disp_digits <= hex_ext[DW-1:0];
              disp_hex    <= 1'b1;
              disp_blank  <= blank_lz;
              overflow    <= hex_ovf;
            end else begin
              shift_reg  <= load_value;
              bcd_acc    <= '0;
              ovf_sticky <= 1'b0;
              bit_cnt    <= '0;
              conv_blank <= blank_lz;
              state      <= CONV;
            end
          end
        end
        CONV: begin
          shift_reg  <= shift_next;
          bcd_acc    <= bcd_next;
          ovf_sticky <= ovf_sticky | carry_out;
          bit_cnt    <= bit_cnt + CW'(1);
          // Last bit: the display switches to the new digits and overflow
          // together, so the old value stays up for the whole conversion.
          if (bit_cnt == CW'(BIN_WIDTH - 1)) begin
            disp_digits <= bcd_next;
            overflow    <= ovf_sticky | carry_out;
            disp_hex    <= 1'b0;
            disp_blank  <= conv_blank;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'b0000001;
      4'h1: seg_code = 7'b1001111;
      4'h2: seg_code = 7'b0010010;
      4'h3: seg_code = 7'b0000110;
      4'h4: seg_code = 7'b1001100;
      4'h5: seg_code = 7'b0100100;
      4'h6: seg_code = 7'b0100000;
      4'h7: seg_code = 7'b0001111;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0000100;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b1100000;
      4'hC: seg_code = 7'b0110001;
      4'hD: seg_code = 7'b1000010;
      4'hE: seg_code = 7'b0110000;
      default: seg_code = 7'b0111000;
    endcase
  endfunction

  // lz_mask[i] is set when digit i and every digit above it are zero.
  // Digit 0 is never blanked so a zero value still shows one '0'.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_so_far;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [6:0]            seg_next;

  always_comb begin
    zero_so_far = 1'b1;
    lz_mask     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_so_far = zero_so_far && (disp_digits[4*i +: 4] == 4'd0);
      lz_mask[i]  = zero_so_far;
    end
    lz_mask[0] = 1'b0;

    // Scan index 0 is the leftmost digit, i.e. digit NUM_DIGITS-1.
    cur_digit  = '0;
    cur_blank  = 1'b0;
    anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == NUM_DIGITS - 1 - int'(digit_idx)) begin
        cur_digit     = disp_digits[4*i +: 4];
        cur_blank     = lz_mask[i];
        anode_next[i] = 1'b0;
      end
    end

    if (overflow && !disp_hex)               seg_next = 7'b1111110;
    else if (disp_blank && !overflow && cur_blank) seg_next = 7'b1111111;
    else                                     seg_next = seg_code(cur_digit);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      prescaler      <= '0;
      digit_idx      <= '0;
      Anode_Activate <= '1;
      LED_out        <= 7'b1111111;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (prescaler == '1) begin
        digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end
      Anode_Activate <= anode_next;
      LED_out        <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Bench for seg7_bcd_display: a 4-digit/16-bit instance and a 6-digit/20-bit
// instance, both with a fast refresh (REFRESH_BITS=2, 4 cycles per digit).
// Expected digits come from plain divide/modulo arithmetic on the value.
module tb_seg7_bcd_display;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        lv4, hm4, bl4, rdy4, busy4, ovf4;
  logic [15:0] val4;
  logic [3:0]  an4;
  logic [6:0]  led4;

  logic        lv6, hm6, bl6, rdy6, busy6, ovf6;
  logic [19:0] val6;
  logic [5:0]  an6;
  logic [6:0]  led6;

  seg7_bcd_display #(.NUM_DIGITS(4), .BIN_WIDTH(16), .REFRESH_BITS(2)) dut4 (
    .clock_100Mhz(clk), .reset(reset), .load_valid(lv4), .load_ready(rdy4),
    .load_value(val4), .hex_mode(hm4), .blank_lz(bl4), .busy(busy4),
    .overflow(ovf4), .Anode_Activate(an4), .LED_out(led4));

  seg7_bcd_display #(.NUM_DIGITS(6), .BIN_WIDTH(20), .REFRESH_BITS(2)) dut6 (
    .clock_100Mhz(clk), .reset(reset), .load_valid(lv6), .load_ready(rdy6),
    .load_value(val6), .hex_mode(hm6), .blank_lz(bl6), .busy(busy6),
    .overflow(ovf6), .Anode_Activate(an6), .LED_out(led6));

  // sel chooses which instance the driver tasks and monitors talk to
  int         sel;
  logic [7:0] mon_an;
  logic [6:0] mon_led;
  logic       mon_rdy, mon_busy, mon_ovf;

  always_comb begin
    if (sel == 1) begin
      mon_an = {2'b11, an6}; mon_led = led6;
      mon_rdy = rdy6; mon_busy = busy6; mon_ovf = ovf6;
    end else begin
      mon_an = {4'hF, an4}; mon_led = led4;
      mon_rdy = rdy4; mon_busy = busy4; mon_ovf = ovf4;
    end
  end

  // ---------------- scoreboard / model ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [6:0] exp_led [8];
  logic       exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected cathodes for every anode position (bit i = digit i, 0 = rightmost)
  task automatic model(input longint value, input bit hex, input bit blank, input int nd);
    int     d [8];
    longint v;
    int     msnz;
    v = value;
    for (int i = 0; i < 8; i++) d[i] = 0;
    for (int i = 0; i < nd; i++) begin
      if (hex) begin d[i] = int'(v & 15); v = v >> 4; end
      else     begin d[i] = int'(v % 10); v = v / 10; end
    end
    exp_ovf = (v != 0);
    msnz = 0;
    for (int i = 0; i < nd; i++) if (d[i] != 0) msnz = i;
    for (int i = 0; i < 8; i++) exp_led[i] = 7'b1111111;
    for (int i = 0; i < nd; i++) begin
      if (!hex && exp_ovf)                  exp_led[i] = 7'b1111110;
      else if (blank && !exp_ovf && i > msnz) exp_led[i] = 7'b1111111;
      else                                  exp_led[i] = seg_tab[d[i]];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit valid, input longint value, input bit hex, input bit blank);
    if (sel == 1) begin lv6 = valid; val6 = 20'(value); hm6 = hex; bl6 = blank; end
    else          begin lv4 = valid; val4 = 16'(value); hm4 = hex; bl4 = blank; end
  endtask

  // Watches two full scan rounds: one anode low, its cathodes match the
  // model, positions step leftmost->rightmost and wrap, 4 cycles per digit.
  task automatic scan_check(input int nd);
    int prev_pos, run, zeros, pos;
    bit first_run;
    prev_pos = -1; run = 0; first_run = 1'b1;
    for (int c = 0; c < 8 * nd + 2; c++) begin
      zeros = 0; pos = -1;
      for (int i = 0; i < 8; i++) if (!mon_an[i]) begin zeros++; pos = i; end
      check("one_anode_low", zeros, 1);
      if (pos >= 0) begin
        check($sformatf("led_pos%0d", pos), mon_led, exp_led[pos]);
        if (prev_pos >= 0 && pos != prev_pos) begin
          check("scan_order", pos, (prev_pos == 0) ? nd - 1 : prev_pos - 1);
          if (!first_run) check("dwell", run, 4);
          first_run = 1'b0;
          run = 1;
        end else run++;
        prev_pos = pos;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_load(input longint value, input bit hex, input bit blank, input bit inject);
    int nd, bw, n;
    nd = (sel == 1) ? 6 : 4;
    bw = (sel == 1) ? 20 : 16;
    model(value, hex, blank, nd);
    @(negedge clk);
    check("ready_idle", mon_rdy, 1);
    drive(1'b1, value, hex, blank);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    if (hex) begin
      check("hex_ready", mon_rdy, 1);
      check("hex_busy", mon_busy, 0);
    end else begin
      n = 0;
      while (mon_busy && n < 200) begin
        n++;
        if (inject && n == 3) begin
          check("ready_busy", mon_rdy, 0);
          drive(1'b1, 9999, 1'b0, 1'b0);
        end
        if (inject && n == 6) drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
      end
      check("latency", n, bw);
      check("ready_after", mon_rdy, 1);
    end
    check("overflow", mon_ovf, exp_ovf);
    @(negedge clk);
    scan_check(nd);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    sel = 0;
    lv4 = 0; hm4 = 0; bl4 = 0; val4 = '0;
    lv6 = 0; hm6 = 0; bl6 = 0; val6 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      check("rst_anodes", mon_an, 8'hFF);
      check("rst_led", mon_led, 7'h7F);
      check("rst_ready", mon_rdy, 1);
      check("rst_busy", mon_busy, 0);
      check("rst_ovf", mon_ovf, 0);
    end
    sel = 0; #1;

    reset = 1'b0;
    @(negedge clk);
    check("first_anode", mon_an, 8'hF7);
    model(0, 1'b0, 1'b0, 4);
    scan_check(4);

    do_load(1234, 1'b0, 1'b0, 1'b0);
    do_load(64'hBEEF, 1'b1, 1'b0, 1'b0);
    do_load(12345, 1'b0, 1'b0, 1'b0);
    do_load(0, 1'b0, 1'b1, 1'b0);
    do_load(4321, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a conversion
    @(negedge clk);
    drive(1'b1, 5678, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("midconv_busy", mon_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", mon_busy, 0);
    check("abort_ready", mon_rdy, 1);
    check("abort_ovf", mon_ovf, 0);
    model(0, 1'b0, 1'b0, 4);
    @(negedge clk);
    scan_check(4);

    for (int k = 0; k < 24; k++) begin
      do_load(longint'($urandom_range(0, 65535) >> $urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    sel = 1; #1;
    do_load(999999, 1'b0, 1'b0, 1'b0);
    do_load(1000000, 1'b0, 1'b1, 1'b0);
    do_load(64'hABCDE, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      do_load(longint'($urandom_range(0, 1048575) >> $urandom_range(0, 19)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
